// File: rtl/conv_stage_ctrl.sv
// conv_stage_ctrl: controller for one 1-D CNN convolution stage.
// It fills a per-channel sliding window from the input stream and appends
// trailing zero padding. Each window goes to an external conv engine, and the
// returned results are max-pooled into output vectors.
// Build option: define CONV_STAGE_RELU_EN to clamp negative conv results to
// zero before pooling. With it undefined, raw signed results are pooled.
module conv_stage_ctrl #(
  parameter int CH     = 8,
  parameter int DW     = 8,
  parameter int K      = 5,
  parameter int POOL   = 4,
  parameter int IN_LEN = 96,
  parameter int PAD    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DW-1:0]     in_data,
  output logic                 win_valid,
  output logic [CH*K*DW-1:0]   win_data,
  input  logic                 conv_valid,
  input  logic [CH*DW-1:0]     conv_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DW-1:0]     out_data
);

  localparam int N_CONV = IN_LEN + PAD - K + 1;
  localparam int SW     = $clog2(IN_LEN + 1);
  localparam int CW     = $clog2(N_CONV + 1);
  localparam int PW     = (POOL > 1) ? $clog2(POOL) : 1;

  localparam logic [SW-1:0] IN_LEN_C    = SW'(IN_LEN);
  localparam logic [SW-1:0] K_LAST_C    = SW'(K - 1);
  localparam logic [CW-1:0] N_CONV_C    = CW'(N_CONV);
  localparam logic [PW-1:0] POOL_LAST_C = PW'(POOL - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, ISSUE, WAIT, ADVANCE, EMIT, DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [SW-1:0]         sample_cnt_reg, sample_cnt_next;
  logic [CW-1:0]         conv_cnt_reg, conv_cnt_next;
  logic [PW-1:0]         pool_cnt_reg, pool_cnt_next;
  logic signed [DW-1:0]  win_reg [CH][K];
  logic signed [DW-1:0]  win_next [CH][K];
  logic signed [DW-1:0]  pool_max_reg [CH];
  logic signed [DW-1:0]  pool_max_next [CH];
  logic [CH*DW-1:0]      out_data_reg, out_data_next;
  logic [CH*DW-1:0]      res_flat;
  logic                  shift_en, shift_zero;
  logic                  in_ready_reg, win_valid_reg, out_valid_reg;
  logic                  busy_reg, done_reg;

  // Per-channel result conditioning and flattening of the window onto win_data.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
`ifdef CONV_STAGE_RELU_EN
      assign res_flat[gi*DW +: DW] = conv_data[gi*DW + DW - 1] ? '0 : conv_data[gi*DW +: DW];
`else
      assign res_flat[gi*DW +: DW] = conv_data[gi*DW +: DW];
`endif
      for (genvar gs = 0; gs < K; gs++) begin : g_slot
        assign win_data[(gi*K + gs)*DW +: DW] = win_reg[gi][gs];
      end
    end
  endgenerate

  assign in_ready  = in_ready_reg;
  assign win_valid = win_valid_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign out_data  = out_data_reg;

  // Next-state logic: frame sequencing, counters, window shift and pooling.
  always_comb begin
    state_next      = state_reg;
    sample_cnt_next = sample_cnt_reg;
    conv_cnt_next   = conv_cnt_reg;
    pool_cnt_next   = pool_cnt_reg;
    win_next        = win_reg;
    pool_max_next   = pool_max_reg;
    out_data_next   = out_data_reg;
    shift_en        = 1'b0;
    shift_zero      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = FILL;
          sample_cnt_next = '0;
          conv_cnt_next   = '0;
          pool_cnt_next   = '0;
          for (int c = 0; c < CH; c++) begin
            for (int s = 0; s < K; s++) begin
              win_next[c][s] = '0;
            end
          end
        end
      end
      FILL: begin
        if (in_valid && in_ready_reg) begin
          shift_en        = 1'b1;
          sample_cnt_next = sample_cnt_reg + SW'(1);
          if (sample_cnt_reg == K_LAST_C) begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (conv_valid) begin
          conv_cnt_next = conv_cnt_reg + CW'(1);
          // A tie keeps the held value: only a strictly larger result replaces it.
          for (int c = 0; c < CH; c++) begin
            if (pool_cnt_reg == '0 || $signed(res_flat[c*DW +: DW]) > pool_max_reg[c]) begin
              pool_max_next[c] = $signed(res_flat[c*DW +: DW]);
            end
          end
          if (pool_cnt_reg == POOL_LAST_C) begin
            pool_cnt_next = '0;
            for (int c = 0; c < CH; c++) begin
              out_data_next[c*DW +: DW] = pool_max_next[c];
            end
            state_next = EMIT;
          end else begin
            pool_cnt_next = pool_cnt_reg + PW'(1);
            state_next    = ADVANCE;
          end
        end
      end
      ADVANCE: begin
        if (sample_cnt_reg < IN_LEN_C) begin
          if (in_valid && in_ready_reg) begin
            shift_en        = 1'b1;
            sample_cnt_next = sample_cnt_reg + SW'(1);
            state_next      = ISSUE;
          end
        end else begin
          // Trailing padding: shift a zero sample in without a handshake.
          shift_en   = 1'b1;
          shift_zero = 1'b1;
          state_next = ISSUE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_next = (conv_cnt_reg == N_CONV_C) ? DONE : ADVANCE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (shift_en) begin
      for (int c = 0; c < CH; c++) begin
        for (int s = K - 1; s > 0; s--) begin
          win_next[c][s] = win_reg[c][s-1];
        end
        win_next[c][0] = shift_zero ? '0 : $signed(in_data[c*DW +: DW]);
      end
    end
  end

  // State, counters, window, pooling accumulator and output vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= '0;
      conv_cnt_reg   <= '0;
      pool_cnt_reg   <= '0;
      out_data_reg   <= '0;
      for (int c = 0; c < CH; c++) begin
        pool_max_reg[c] <= '0;
        for (int s = 0; s < K; s++) begin
          win_reg[c][s] <= '0;
        end
      end
    end else begin
      state_reg      <= state_next;
      sample_cnt_reg <= sample_cnt_next;
      conv_cnt_reg   <= conv_cnt_next;
      pool_cnt_reg   <= pool_cnt_next;
      out_data_reg   <= out_data_next;
      pool_max_reg   <= pool_max_next;
      win_reg        <= win_next;
    end
  end

  // Handshake and status flags, registered from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_reg  <= 1'b0;
      win_valid_reg <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      in_ready_reg  <= (state_next == FILL) ||
                       (state_next == ADVANCE && sample_cnt_next < IN_LEN_C);
      win_valid_reg <= (state_next == ISSUE);
      out_valid_reg <= (state_next == EMIT);
      busy_reg      <= state_next inside {FILL, ISSUE, WAIT, ADVANCE, EMIT};
      done_reg      <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_conv_stage_ctrl.sv
// Testbench for conv_stage_ctrl: ramp, negative, backpressure, input gaps,
// mid-frame reset and spurious controls, checked through an output scoreboard.
module tb_conv_stage_ctrl;

  localparam int CH     = 8;
  localparam int DW     = 8;
  localparam int K      = 5;
  localparam int POOL   = 4;
  localparam int IN_LEN = 96;
  localparam int PAD    = 4;
  localparam int N_OUT  = (IN_LEN + PAD - K + 1) / POOL;
  localparam int VW     = CH * DW;

  logic              clk = 1'b0;
  logic              rst, start, busy, done;
  logic              in_valid, in_ready, win_valid, conv_valid, out_valid, out_ready;
  logic [VW-1:0]     in_data, conv_data, out_data;
  logic [CH*K*DW-1:0] win_data;

  conv_stage_ctrl #(
    .CH(CH), .DW(DW), .K(K), .POOL(POOL), .IN_LEN(IN_LEN), .PAD(PAD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .win_valid(win_valid), .win_data(win_data),
    .conv_valid(conv_valid), .conv_data(conv_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int            n_pass = 0;
  int            n_total = 0;
  logic [VW-1:0] exp_q [$];
  int            in_idx = 0;
  int            cyc = 0;
  bit            feed_en = 0, gap_mode = 0, neg_mode = 0, spur_mode = 0, stall_mode = 0;
  int            out_cnt = 0, done_cnt = 0, stall_at = -1, stall_cyc = 0;
  logic [VW-1:0] held;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Hand-computed pooled outputs of the ramp frame and the constant -5 frame.
  function automatic logic [VW-1:0] exp_vec(input bit neg, input int g);
    logic [DW-1:0] b;
    if (neg) begin
`ifdef CONV_STAGE_RELU_EN
      b = 8'h00;
`else
      b = 8'hFB;
`endif
    end else if (g < 22) b = DW'(4 * g + 7);
    else if (g == 22) b = 8'd95;
    else b = 8'd0;
    return {CH{b}};
  endfunction

  // Input stream: sample i = i on every channel, optional every-other-cycle gaps.
  initial begin
    bit took;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) in_idx++;
      cyc++;
      in_valid = feed_en && (in_idx < IN_LEN) && (!gap_mode || cyc[0]);
      in_data  = {CH{DW'(in_idx)}};
    end
  end

  // Conv engine model: returns window slot 0 (or -5) two cycles after win_valid.
  initial begin
    int            delay;
    logic [VW-1:0] ret;
    delay = 0;
    ret = '0;
    conv_valid = 1'b0;
    conv_data  = '0;
    forever begin
      @(posedge clk); #1;
      conv_valid = 1'b0;
      if (rst) delay = 0;
      else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          conv_valid = 1'b1;
          conv_data  = ret;
        end
      end else if (win_valid) begin
        for (int c = 0; c < CH; c++)
          ret[c*DW +: DW] = neg_mode ? 8'hFB : win_data[c*K*DW +: DW];
        delay = 1;
      end else if (spur_mode && (out_valid || in_ready)) begin
        conv_valid = 1'b1;
        conv_data  = {CH{8'h7F}};
      end
    end
  end

  // Output monitor: drives out_ready, pops the scoreboard on each handshake.
  initial begin
    logic [VW-1:0] e;
    out_ready = 1'b1;
    held = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 0);
      end
      if (rst) begin
        out_ready = 1'b1;
      end else if (out_valid) begin
        if (stall_mode && out_cnt == stall_at && stall_cyc < 10) begin
          out_ready = 1'b0;
          if (stall_cyc == 0) held = out_data;
          else check("stall_data", out_data, held);
          check("stall_in_ready", in_ready, 0);
          check("stall_win_valid", win_valid, 0);
          stall_cyc++;
        end else begin
          out_ready = 1'b1;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL out_extra: got %h expected no output", out_data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("out_%0d", out_cnt), out_data, e);
          end
          out_cnt++;
        end
      end else begin
        if (stall_mode && out_cnt == stall_at && stall_cyc > 0 && stall_cyc < 10)
          check("stall_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_win_data"}, |win_data, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic start_frame(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_in_ready"}, in_ready, 1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      start = spur_mode && busy && (k % 3 == 0);
      if (done) break;
    end
    start = 1'b0;
    check({tag, "_no_timeout"}, k < 5000, 1);
  endtask

  task automatic run_frame(input bit neg, input string tag);
    int o0, d0;
    for (int g = 0; g < N_OUT; g++) exp_q.push_back(exp_vec(neg, g));
    @(posedge clk); #2;
    o0 = out_cnt;
    d0 = done_cnt;
    neg_mode = neg;
    in_idx = 0;
    feed_en = 1'b1;
    start_frame(tag);
    wait_done(tag);
    repeat (3) @(negedge clk);
    check({tag, "_n_outputs"}, out_cnt - o0, N_OUT);
    check({tag, "_one_done"}, done_cnt - d0, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_samples_taken"}, in_idx, IN_LEN);
    feed_en = 1'b0;
  endtask

  initial begin
    int k;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    run_frame(1'b0, "ramp");
    run_frame(1'b1, "negative");

    @(posedge clk); #2;
    stall_mode = 1'b1;
    stall_at   = out_cnt + 3;
    stall_cyc  = 0;
    run_frame(1'b0, "backpressure");
    check("stall_cycles", stall_cyc, 10);
    stall_mode = 1'b0;

    gap_mode = 1'b1;
    run_frame(1'b0, "gaps");
    gap_mode = 1'b0;

    // Reset after 40 accepted samples, then a complete fresh frame.
    for (int g = 0; g < N_OUT; g++) exp_q.push_back(exp_vec(1'b0, g));
    @(posedge clk); #2;
    neg_mode = 1'b0;
    in_idx = 0;
    feed_en = 1'b1;
    start_frame("midrst");
    for (k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      if (in_idx >= 40) break;
    end
    check("midrst_reached_40", k < 3000, 1);
    rst = 1'b1;
    feed_en = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    run_frame(1'b0, "after_rst");

    spur_mode = 1'b1;
    run_frame(1'b0, "spurious");
    spur_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_stage_ctrl.md
# conv_stage_ctrl

Parametrised controller for one 1-D CNN convolution stage. It streams multichannel samples into a per-channel sliding window and appends trailing zero padding. It hands each window to an external convolution engine, applies ReLU to the returned results, and max-pools them into output vectors. It sits between the previous layer's output stream and the next layer's input, with valid/ready handshakes on both streams and a request/response handshake to the convolution engine.

## Interface
- CH, 8, channel count
- DW, 8, signed sample/result width
- K, 5, kernel length (window depth)
- POOL, 4, conv results per pooled output
- IN_LEN, 96, samples per frame
- PAD, 4, trailing zero samples per frame; legal only if (IN_LEN+PAD-K+1) % POOL == 0
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame start pulse
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at frame end
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accepted when in_valid & in_ready
- in_data  in  CH*DW  channel c at [c*DW +: DW]
- win_valid  out  1  one-cycle request to the conv engine
- win_data  out  CH*K*DW  channel c, slot s at [(c*K+s)*DW +: DW]; slot 0 is newest
- conv_valid  in  1  conv result valid (any latency ≥1)
- conv_data  in  CH*DW  signed conv result per channel
- out_valid  out  1  pooled vector valid
- out_ready  in  1  downstream accept
- out_data  out  CH*DW  pooled vector

## Operation
- N_CONV = IN_LEN+PAD-K+1 conv results per frame, stride 1. N_OUT = N_CONV/POOL pooled outputs per frame.
- States: IDLE, FILL, ISSUE, WAIT, ADVANCE, EMIT, DONE.
- IDLE: on start, clear the window, sample counter, conv counter and pool counter; go to FILL. start in any other state is ignored.
- FILL: in_ready=1. Each accepted sample shifts into slot 0 and slot s moves to s+1. After K accepted samples, go to ISSUE.
- ISSUE: win_valid=1 for one cycle; go to WAIT.
- WAIT: on conv_valid, compute r = ReLU(conv_data) per channel.
  - If pool counter is 0, load pool_max with r; otherwise pool_max = signed max(pool_max, r). Ties keep the held value.
  - Increment the conv and pool counters.
  - If the pool counter reaches POOL: copy pool_max to out_data, reset the pool counter, go to EMIT. Otherwise go to ADVANCE.
- EMIT: out_valid=1 until out_ready. On the handshake: if the conv counter equals N_CONV, go to DONE; otherwise go to ADVANCE.
- ADVANCE:
  - While samples accepted < IN_LEN: in_ready=1; on handshake, shift in in_data and go to ISSUE.
  - After that: shift in zero without a handshake (in_ready=0) and go to ISSUE in the same cycle.
- DONE: done=1 for one cycle; go to IDLE.
- conv_valid outside WAIT is ignored. in_valid is ignored while in_ready=0.
- Reset at any time: state IDLE and all counters zero, whether mid-frame or mid-handshake.
- Reset values: in_ready=0, win_valid=0, out_valid=0, busy=0, done=0, win_data=0, out_data=0.

## Timing
- All outputs are registered.
- start acceptance: busy=1 and in_ready=1 the next cycle.
- FILL to first win_valid: 1 cycle after the K-th input handshake.
- conv_valid to state change: 1 cycle. out_valid asserts 1 cycle after the POOL-th conv_valid.
- ADVANCE with an input already valid: in_ready is high one cycle, then win_valid the following cycle.
- ADVANCE during padding: 1 cycle.
- out_data is stable while out_valid=1 and out_ready=0. No win_valid is issued and in_ready stays low during EMIT.
- done fires 1 cycle after the last out handshake; busy falls in the same cycle done rises.

## Configuration
- CONV_STAGE_RELU_EN defined: ReLU is applied before pooling, so negative results become 0.
- CONV_STAGE_RELU_EN undefined: raw signed conv results are pooled and out_data may be negative.

## Test plan
- Ramp frame, defaults. Stimulus: sample i = i on all channels; conv model returns win slot 0 after 2 cycles. Required: 24 outputs, output g = 4g+7 for g<22, output 22 = 95, output 23 = 0; exactly one done pulse.
- Negative results. Stimulus: conv model always returns -5. Required: every out_data byte 0x00 with CONV_STAGE_RELU_EN, 0xFB without.
- Backpressure. Stimulus: out_ready low for 10 cycles on output 3. Required: out_valid held, out_data unchanged, in_ready=0, win_valid=0 during the stall; the frame still completes with 24 outputs.
- Input gaps. Stimulus: in_valid deasserted every other cycle. Required: output values identical to the ramp test; no sample is lost or duplicated.
- Reset mid-frame. Stimulus: rst after 40 accepted samples. Required: all outputs at reset values the next cycle; a new start then yields a full, correct 24-output frame.
- Spurious controls. Stimulus: start and conv_valid pulses while in FILL or EMIT. Required: no state change, no extra outputs, counters unaffected.
